// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames start/data/parity/stop bits from an oversampled line
// and reports the received word together with parity, stop and start-glitch status.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Sampled_Bit,
    output logic                  Data_samp_en,
    output logic [5:0]            edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_err,
    output logic                  Stp_err,
    output logic                  Strt_glitch
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_r;
    logic [5:0]              prescale_l_r;
    logic                    par_en_l_r;
    logic                    par_typ_l_r;
    logic                    par_fail_r;
    logic [BCW-1:0]          bit_count_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [5:0]              prescale_sel_s;
    logic                    bit_end_s;

    // Expected parity bit: even parity is the XOR of the data, odd parity its inverse.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Legalise the requested oversampling ratio; anything unsupported falls back to 8.
    always_comb begin
        prescale_sel_s = 6'd8;
        case (Prescale)
            6'd8:    prescale_sel_s = 6'd8;
            6'd16:   prescale_sel_s = 6'd16;
            6'd32:   prescale_sel_s = 6'd32;
            default: prescale_sel_s = 6'd8;
        endcase
    end

    // Last oversample of the current bit.
    always_comb begin
        if (edge_count == (prescale_l_r - 6'd1)) begin
            bit_end_s = 1'b1;
        end else begin
            bit_end_s = 1'b0;
        end
    end

    // Frame FSM with all status and data outputs registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= IDLE;
            prescale_l_r <= 6'd8;
            par_en_l_r   <= 1'b0;
            par_typ_l_r  <= 1'b0;
            par_fail_r   <= 1'b0;
            bit_count_r  <= '0;
            shift_r      <= '0;
            Data_samp_en <= 1'b0;
            edge_count   <= 6'd0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Par_err      <= 1'b0;
            Stp_err      <= 1'b0;
            Strt_glitch  <= 1'b0;
        end else begin
            Data_Valid  <= 1'b0;
            Strt_glitch <= 1'b0;
            if (state_r != IDLE) begin
                if (bit_end_s) begin
                    edge_count <= 6'd0;
                end else begin
                    edge_count <= edge_count + 6'd1;
                end
            end else begin
                edge_count <= 6'd0;
            end

            case (state_r)
                IDLE: begin
                    if (!RX_IN) begin
                        state_r      <= START;
                        Data_samp_en <= 1'b1;
                        bit_count_r  <= '0;
                        par_fail_r   <= 1'b0;
                        prescale_l_r <= prescale_sel_s;
                        par_en_l_r   <= PAR_EN;
                        par_typ_l_r  <= PAR_TYP;
                    end else begin
                        Data_samp_en <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        if (Sampled_Bit) begin
                            state_r      <= IDLE;
                            Data_samp_en <= 1'b0;
                            Strt_glitch  <= 1'b1;
                        end else begin
                            state_r     <= DATA;
                            bit_count_r <= '0;
                        end
                    end else begin
                        state_r <= START;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        // LSB arrives first, so new bits enter at the top and walk down.
                        shift_r     <= {Sampled_Bit, shift_r[DATA_WIDTH-1:1]};
                        bit_count_r <= bit_count_r + BCW'(1);
                        if (bit_count_r == BCW'(DATA_WIDTH - 1)) begin
                            if (par_en_l_r) begin
                                state_r <= PARITY;
                            end else begin
                                state_r <= STOP;
                            end
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        par_fail_r <= (Sampled_Bit != parity_bit(shift_r, par_typ_l_r));
                        state_r    <= STOP;
                    end else begin
                        state_r <= PARITY;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        Stp_err      <= ~Sampled_Bit;
                        Par_err      <= par_fail_r;
                        state_r      <= IDLE;
                        Data_samp_en <= 1'b0;
                        if (!par_fail_r && Sampled_Bit) begin
                            P_DATA     <= shift_r;
                            Data_Valid <= 1'b1;
                        end else begin
                            P_DATA <= P_DATA;
                        end
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    Data_samp_en <= 1'b0;
                    edge_count   <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of whole frames plus hand-written glitch,
// mid-frame reset and back-to-back sequences.
module tb_uart_rx_ctrl;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Sampled_Bit;
    logic       Data_samp_en;
    logic [5:0] edge_count;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_err;
    logic       Stp_err;
    logic       Strt_glitch;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Sampled_Bit  (Sampled_Bit),
        .Data_samp_en (Data_samp_en),
        .edge_count   (edge_count),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Par_err      (Par_err),
        .Stp_err      (Stp_err),
        .Strt_glitch  (Strt_glitch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] ps_in;
        int         ps_time;
        logic       par_en;
        logic       par_typ;
        logic [7:0] data;
        logic       par_bit;
        logic       stop;
        logic       exp_dv;
        logic [7:0] exp_pdata;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic pe,
                                             input logic pb, input logic sb);
        logic [11:0] f;
        f = 12'hFFF;
        f[0] = 1'b0;
        f[8:1] = d;
        if (pe) begin
            f[9]  = pb;
            f[10] = sb;
        end else begin
            f[9] = sb;
        end
        return f;
    endfunction

    // Called on a negedge with the line idle; returns on the negedge after the stop-bit end.
    task automatic send_frame(input int ps, input logic [11:0] bits, input int nb);
        RX_IN = 1'b0;
        Sampled_Bit = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < nb; i++) begin
            @(negedge CLK);
            RX_IN = bits[i];
            Sampled_Bit = bits[i];
            repeat (ps) @(posedge CLK);
        end
        @(negedge CLK);
        RX_IN = 1'b1;
        Sampled_Bit = 1'b1;
    endtask

    initial begin
        logic [11:0] fr;
        vecs[0] = '{6'd8,  8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{6'd32, 32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[3] = '{6'd20, 8,  1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[4] = '{6'd16, 16, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0};
        vecs[5] = '{6'd8,  8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};

        RST = 1'b0;
        RX_IN = 1'b1;
        Sampled_Bit = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_samp_en", 32'(Data_samp_en), 32'd0);
        chk("reset_edge_count", 32'(edge_count), 32'd0);
        chk("reset_p_data", 32'(P_DATA), 32'd0);
        chk("reset_flags", {28'd0, Data_Valid, Par_err, Stp_err, Strt_glitch}, 32'd0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_after_reset", 32'(Data_samp_en), 32'd0);

        for (int v = 0; v < 6; v++) begin
            Prescale = vecs[v].ps_in;
            PAR_EN = vecs[v].par_en;
            PAR_TYP = vecs[v].par_typ;
            fr = mk_frame(vecs[v].data, vecs[v].par_en, vecs[v].par_bit, vecs[v].stop);
            send_frame(vecs[v].ps_time, fr, vecs[v].par_en ? 11 : 10);
            chk($sformatf("v%0d_data_valid", v), 32'(Data_Valid), 32'(vecs[v].exp_dv));
            chk($sformatf("v%0d_p_data", v), 32'(P_DATA), 32'(vecs[v].exp_pdata));
            chk($sformatf("v%0d_par_err", v), 32'(Par_err), 32'(vecs[v].exp_perr));
            chk($sformatf("v%0d_stp_err", v), 32'(Stp_err), 32'(vecs[v].exp_serr));
            chk($sformatf("v%0d_samp_en_idle", v), 32'(Data_samp_en), 32'd0);
            @(negedge CLK);
            chk($sformatf("v%0d_dv_one_cycle", v), 32'(Data_Valid), 32'd0);
        end

        // Start glitch: line low for two cycles only.
        Prescale = 6'd8;
        RX_IN = 1'b0;
        Sampled_Bit = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("glitch_samp_en_start", 32'(Data_samp_en), 32'd1);
        chk("glitch_edge_count_start", 32'(edge_count), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RX_IN = 1'b1;
        Sampled_Bit = 1'b1;
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        chk("glitch_pulse", 32'(Strt_glitch), 32'd1);
        chk("glitch_edge_count", 32'(edge_count), 32'd0);
        chk("glitch_samp_en", 32'(Data_samp_en), 32'd0);
        chk("glitch_no_dv", 32'(Data_Valid), 32'd0);
        @(negedge CLK);
        chk("glitch_pulse_end", 32'(Strt_glitch), 32'd0);

        // Reset asserted three oversamples into data bit 4.
        fr = mk_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b0;
        Sampled_Bit = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            RX_IN = fr[i];
            Sampled_Bit = fr[i];
            repeat ((i == 5) ? 3 : 8) @(posedge CLK);
        end
        #2;
        chk("mid_frame_edge_count", 32'(edge_count), 32'd3);
        chk("mid_frame_samp_en", 32'(Data_samp_en), 32'd1);
        RST = 1'b0;
        #1;
        chk("async_rst_edge_count", 32'(edge_count), 32'd0);
        chk("async_rst_p_data", 32'(P_DATA), 32'd0);
        chk("async_rst_flags", {27'd0, Data_samp_en, Data_Valid, Par_err, Stp_err, Strt_glitch}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        RX_IN = 1'b1;
        Sampled_Bit = 1'b1;
        repeat (3) @(negedge CLK);
        chk("post_rst_idle", 32'(Data_samp_en), 32'd0);
        send_frame(8, mk_frame(8'h5A, 1'b0, 1'b0, 1'b1), 10);
        chk("post_rst_dv", 32'(Data_Valid), 32'd1);
        chk("post_rst_p_data", 32'(P_DATA), 32'h5A);

        // Back-to-back frames at 16x with Prescale disturbed mid-frame 1.
        @(negedge CLK);
        Prescale = 6'd16;
        PAR_EN = 1'b0;
        fork
            send_frame(16, mk_frame(8'hFF, 1'b0, 1'b0, 1'b1), 10);
            begin
                repeat (40) @(negedge CLK);
                Prescale = 6'd8;
                PAR_EN = 1'b1;
                repeat (60) @(negedge CLK);
                Prescale = 6'd16;
                PAR_EN = 1'b0;
            end
        join
        chk("b2b_f1_dv", 32'(Data_Valid), 32'd1);
        chk("b2b_f1_p_data", 32'(P_DATA), 32'hFF);
        send_frame(16, mk_frame(8'h00, 1'b0, 1'b0, 1'b1), 10);
        chk("b2b_f2_dv", 32'(Data_Valid), 32'd1);
        chk("b2b_f2_p_data", 32'(P_DATA), 32'h00);
        chk("b2b_f2_errs", {30'd0, Par_err, Stp_err}, 32'd0);
        @(negedge CLK);
        chk("b2b_dv_end", 32'(Data_Valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
